// File: rtl/tia_pair_link_scheduler.sv
// ----------------------------------------------------------------------------
// tia_pair_link_scheduler
//   Time-shares the op-amp redirect datapath between the two TIA-568B pair
//   channels. ch0 is pairs 1/2-3/6 and ch1 is pairs 5/4-7/8. Each burst runs
//   through these states in order:
//     - IDLE: pick a channel. Arbitration is round-robin on contention.
//     - SETTLE: enable that channel's V+/V- rails and wait for them to settle.
//     - GRANT: grant the path to the channel.
//     - GUARD: both rails off while the path turns around.
//   Everything runs on the rising edge of the 100 MHz link clock.
//
// Ports
//   Clock100MhzP      in   link clock
//   Reset             in   synchronous reset, active-high
//   Req1236/Req5478   in   per-channel path request (level)
//   Done1236/Done5478 in   per-channel end-of-burst pulse (owner only)
//   RailEn1236/5478   out  op-amp rail enable per channel
//   Grant1236/5478    out  path grant per channel
//   Owner             out  0 = ch0, 1 = ch1, valid while a rail is enabled
//   TurnaroundActive  out  high in every guard cycle
//   BurstOverrun      out  one-cycle pulse when the burst length limit ends a grant
// ----------------------------------------------------------------------------
module tia_pair_link_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned MAX_BURST     = 1024,
    parameter int unsigned GUARD_CYCLES  = 4
) (
    input  logic Clock100MhzP,
    input  logic Reset,
    input  logic Req1236,
    input  logic Req5478,
    input  logic Done1236,
    input  logic Done5478,
    output logic RailEn1236,
    output logic RailEn5478,
    output logic Grant1236,
    output logic Grant5478,
    output logic Owner,
    output logic TurnaroundActive,
    output logic BurstOverrun
);

    // One shared phase counter. It is sized for the largest of the three limits.
    localparam int unsigned SG_MAX  = (SETTLE_CYCLES > GUARD_CYCLES) ? SETTLE_CYCLES : GUARD_CYCLES;
    localparam int unsigned LIM_MAX = (MAX_BURST > SG_MAX) ? MAX_BURST : SG_MAX;
    localparam int unsigned CNT_W   = $clog2(LIM_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_GRANT  = 2'd2,
        S_GUARD  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_served_q, last_served_d;
    logic [1:0]       rail_en_q, rail_en_d;
    logic [1:0]       grant_q, grant_d;
    logic             turnaround_q, turnaround_d;
    logic             overrun_q, overrun_d;
    logic             pick;

    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] owner_oh;

    assign req      = {Req5478, Req1236};
    assign done     = {Done5478, Done1236};
    assign owner_oh = owner_q ? 2'b10 : 2'b01;

    // State and registered outputs.
    always_ff @(posedge Clock100MhzP) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            owner_q       <= 1'b0;
            last_served_q <= 1'b1;
            rail_en_q     <= 2'b00;
            grant_q       <= 2'b00;
            turnaround_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            rail_en_q     <= rail_en_d;
            grant_q       <= grant_d;
            turnaround_q  <= turnaround_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        owner_d       = owner_q;
        last_served_d = last_served_q;
        rail_en_d     = rail_en_q;
        grant_d       = grant_q;
        overrun_d     = 1'b0;
        pick          = 1'b0;

        case (state_q)
            S_IDLE: begin
                rail_en_d = 2'b00;
                grant_d   = 2'b00;
                cnt_d     = '0;
                if (req != 2'b00) begin
                    // On contention, serve the channel that did not go last.
                    pick      = (req == 2'b11) ? ~last_served_q : req[1];
                    owner_d   = pick;
                    rail_en_d = pick ? 2'b10 : 2'b01;
                    state_d   = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (!req[owner_q]) begin
                    // The request was withdrawn before the grant. The channel was
                    // never served, so LastServed keeps its value.
                    state_d   = S_GUARD;
                    rail_en_d = 2'b00;
                    grant_d   = 2'b00;
                    cnt_d     = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_GRANT;
                    grant_d = owner_oh;
                    cnt_d   = '0;
                end
            end

            S_GRANT: begin
                // A normal end wins over the length limit when both land in the same cycle.
                if (done[owner_q] || !req[owner_q] || (cnt_q == BURST_LAST)) begin
                    overrun_d     = !(done[owner_q] || !req[owner_q]);
                    state_d       = S_GUARD;
                    rail_en_d     = 2'b00;
                    grant_d       = 2'b00;
                    last_served_d = owner_q;
                    cnt_d         = '0;
                end
            end

            S_GUARD: begin
                rail_en_d = 2'b00;
                grant_d   = 2'b00;
                if (cnt_q == GUARD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                rail_en_d = 2'b00;
                grant_d   = 2'b00;
                cnt_d     = '0;
            end
        endcase

        turnaround_d = (state_d == S_GUARD);
    end

    assign RailEn1236       = rail_en_q[0];
    assign RailEn5478       = rail_en_q[1];
    assign Grant1236        = grant_q[0];
    assign Grant5478        = grant_q[1];
    assign Owner            = owner_q;
    assign TurnaroundActive = turnaround_q;
    assign BurstOverrun     = overrun_q;

endmodule

// File: tb/tb_tia_pair_link_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tia_pair_link_scheduler
//   Directed bench for the pair link scheduler. The DUT is built with
//   SETTLE=8, MAX_BURST=16 and GUARD=4.
//   - A vector table checks reset, settle latency, abort, contention and
//     ignored Done pulses.
//   - Hand-written sequences check alternation, overrun, Done at the limit,
//     and reset in the middle of a grant.
// ----------------------------------------------------------------------------
module tb_tia_pair_link_scheduler;

    logic clk;
    logic rst;
    logic req0, req1, done0, done1;
    logic rail0, rail1, gnt0, gnt1, owner, turn, ovr;

    int total;
    int bad;

    tia_pair_link_scheduler #(
        .SETTLE_CYCLES(8),
        .MAX_BURST    (16),
        .GUARD_CYCLES (4)
    ) dut (
        .Clock100MhzP    (clk),
        .Reset           (rst),
        .Req1236         (req0),
        .Req5478         (req1),
        .Done1236        (done0),
        .Done5478        (done1),
        .RailEn1236      (rail0),
        .RailEn5478      (rail1),
        .Grant1236       (gnt0),
        .Grant5478       (gnt1),
        .Owner           (owner),
        .TurnaroundActive(turn),
        .BurstOverrun    (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs: {rst, req0, req1, done0, done1}
    // Expected outputs: {rail0, rail1, gnt0, gnt1, owner, turn, ovr}
    typedef struct {
        logic [4:0] in;
        logic [6:0] ex;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] E_IDLE  = 7'b000_0000;
    localparam logic [6:0] E_RL0   = 7'b100_0000;
    localparam logic [6:0] E_RL0G0 = 7'b101_0000;
    localparam logic [6:0] E_RL1   = 7'b010_0100;
    localparam logic [6:0] E_RL1G1 = 7'b010_1100;
    localparam logic [6:0] E_TURN  = 7'b000_0010;

    task automatic add(input int n, input logic [4:0] in, input logic [6:0] ex);
        vec_t v;
        v.in = in;
        v.ex = ex;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {rail0, rail1, gnt0, gnt1, owner, turn, ovr};
    endfunction

    // Step until a grant shows up. Return the cycle count and the channel (-1 on timeout).
    task automatic wait_grant(output int n, output int ch);
        n  = 0;
        ch = -1;
        for (int k = 0; k < 60; k++) begin
            step();
            n++;
            if (gnt0 === 1'b1) begin ch = 0; break; end
            if (gnt1 === 1'b1) begin ch = 1; break; end
        end
    endtask

    // Count the guard cycles from the current one (TurnaroundActive assumed high now).
    task automatic count_guard(output int g, inout int ovr_cnt);
        g = (turn === 1'b1) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ovr === 1'b1) ovr_cnt++;
            if (turn === 1'b1) g++;
            else break;
        end
    endtask

    // Invariants, checked on every cycle.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            total++;
            if ((rail0 & rail1) === 1'b1) begin
                bad++;
                $display("FAIL inv_rails_exclusive: rail0=%b rail1=%b at %0t", rail0, rail1, $time);
            end
            total++;
            if (((gnt0 & ~rail0) | (gnt1 & ~rail1)) === 1'b1) begin
                bad++;
                $display("FAIL inv_grant_needs_rail: g=%b%b r=%b%b at %0t", gnt1, gnt0, rail1, rail0, $time);
            end
        end
    end

    initial begin
        int n, ch, g, ovr_cnt, gc;
        logic [6:0] a, e;
        total = 0;
        bad   = 0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; done0 = 1'b0; done1 = 1'b0;

        // Reset, then ch0 alone: RailEn after 1 edge, Grant after 9, then Done.
        add(1, 5'b10000, E_IDLE);
        add(8, 5'b01000, E_RL0);
        add(4, 5'b01000, E_RL0G0);
        add(1, 5'b00010, E_TURN);
        add(3, 5'b00000, E_TURN);
        add(1, 5'b00000, E_IDLE);
        add(1, 5'b00010, E_IDLE);   // Done outside GRANT has no effect
        // Reset restores LastServed=1. ch0 then aborts in SETTLE cycle 3.
        add(1, 5'b10000, E_IDLE);
        add(3, 5'b01000, E_RL0);
        add(4, 5'b00000, E_TURN);
        add(1, 5'b00000, E_IDLE);
        // Contention: ch0 must still win, because LastServed did not change on the abort.
        add(8, 5'b01100, E_RL0);
        add(2, 5'b01100, E_RL0G0);
        add(1, 5'b01101, E_RL0G0);  // non-owner Done ignored
        add(1, 5'b01100, E_RL0G0);
        add(1, 5'b01110, E_TURN);
        add(3, 5'b00100, E_TURN);
        add(1, 5'b00100, E_IDLE);
        add(8, 5'b00100, E_RL1);
        add(2, 5'b00100, E_RL1G1);
        add(1, 5'b00101, E_TURN);
        add(3, 5'b00000, E_TURN);
        add(1, 5'b00000, E_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            {rst, req0, req1, done0, done1} = vecs[i].in;
            step();
            a = outs();
            e = vecs[i].ex;
            if (e[6:5] == 2'b00) begin
                a[2] = 1'b0;   // Owner is only meaningful while a rail is enabled
                e[2] = 1'b0;
            end
            chk($sformatf("vec%0d", i), 32'(a), 32'(e));
        end

        // Strict alternation over 10 bursts with both requests held. LastServed is 1 here.
        req0 = 1'b1; req1 = 1'b1;
        for (int b = 0; b < 10; b++) begin
            wait_grant(n, ch);
            chk($sformatf("alt%0d_channel", b), 32'(ch), 32'(b % 2));
            chk($sformatf("alt%0d_owner", b), 32'(owner), 32'(b % 2));
            if (ch == 0) done0 = 1'b1; else done1 = 1'b1;
            step();
            done0 = 1'b0; done1 = 1'b0;
            ovr_cnt = 0;
            count_guard(g, ovr_cnt);
            chk($sformatf("alt%0d_guard_len", b), 32'(g), 32'd4);
        end

        // Overrun: ch1 alone, with no Done.
        req0 = 1'b0; req1 = 1'b1;
        wait_grant(n, ch);
        chk("ovr_channel", 32'(ch), 32'd1);
        gc = 1;
        ovr_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (ovr === 1'b1) ovr_cnt++;
            if (gnt1 === 1'b1) gc++;
            else break;
        end
        req1 = 1'b0;
        chk("ovr_grant_len", 32'(gc), 32'd16);
        chk("ovr_pulse_at_fall", 32'(ovr), 32'd1);
        chk("ovr_rail_off", 32'(rail1), 32'd0);
        count_guard(g, ovr_cnt);
        chk("ovr_guard_len", 32'(g), 32'd4);
        chk("ovr_single_pulse", 32'(ovr_cnt), 32'd1);

        // Done in the limit cycle is a normal end.
        req0 = 1'b1;
        wait_grant(n, ch);
        chk("lim_channel", 32'(ch), 32'd0);
        repeat (15) step();
        chk("lim_grant_in_16th", 32'(gnt0), 32'd1);
        done0 = 1'b1;
        step();
        done0 = 1'b0; req0 = 1'b0;
        chk("lim_grant_fell", 32'(gnt0), 32'd0);
        chk("lim_no_overrun", 32'(ovr), 32'd0);
        chk("lim_guard", 32'(turn), 32'd1);
        step();
        chk("lim_no_overrun_late", 32'(ovr), 32'd0);
        ovr_cnt = 0;
        count_guard(g, ovr_cnt);

        // Reset in GRANT cycle 5, then ch0 is served again from IDLE.
        req0 = 1'b1;
        wait_grant(n, ch);
        repeat (4) step();
        chk("rst_grant_cycle5", 32'(gnt0), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_all_zero", 32'(outs()), 32'd0);
        rst = 1'b0;
        wait_grant(n, ch);
        chk("rst_reserve_channel", 32'(ch), 32'd0);
        chk("rst_reserve_latency", 32'(n), 32'd9);
        done0 = 1'b1;
        step();
        done0 = 1'b0; req0 = 1'b0;
        chk("rst_final_guard", 32'(turn), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
